// File: rtl/fetch_byte_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_byte_feeder                                             |
// | Purpose  : Instruction byte source for the fetch phases. Reads aligned   |
// |            32-bit words from instruction memory, buffers them and hands  |
// |            out one instruction byte per cycle together with its byte     |
// |            address over a valid/ready handshake. A redirect flushes the  |
// |            buffer and restarts streaming at any byte address.            |
// | Macro    : FEEDER_PREFETCH_EN - when defined the word buffer holds two   |
// |            entries and the next word is fetched while the head word is   |
// |            still being consumed (1 byte/cycle sustained). When undefined |
// |            the buffer holds one word and a fetch starts only once the    |
// |            buffer is drained (4 bytes per 6 cycles sustained).           |
// | Ports    : clk, rstn (async, active-low)                                 |
// |            redirect, redirect_pc  - restart stream at a byte address     |
// |            mem_req, mem_addr      - registered word read request         |
// |            mem_rdata              - read data, one cycle after mem_req   |
// |            inst, pc, inst_valid   - current byte, its address, valid     |
// |            inst_ready             - consumer accepts the current byte    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_byte_feeder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        inst,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  input  logic              inst_ready
);

`ifdef FEEDER_PREFETCH_EN
  localparam logic [2:0] c_BUF_N = 3'd2;
`else
  localparam logic [2:0] c_BUF_N = 3'd1;
`endif

  // Word addresses are kept without the two always-zero byte bits.
  localparam int                c_WA_W   = ADDR_W - 2;
  localparam logic [c_WA_W-1:0] c_WA_ONE = {{(c_WA_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic                r_mem_req;
  logic [c_WA_W-1:0]   r_mem_waddr;
  logic [c_WA_W-1:0]   r_fa;          // next sequential fetch word address
  logic                r_epoch;       // flips on every redirect
  logic                r_pend;        // a response is on mem_rdata this cycle
  logic                r_pend_epoch;  // epoch the pending request was issued in

  logic [1:0]          r_count;       // words held in the buffer
  logic [1:0]          r_ofs;         // byte offset into the head word
  logic [31:0]         r_h_data;      // head word
  logic [c_WA_W-1:0]   r_h_waddr;
`ifdef FEEDER_PREFETCH_EN
  logic [31:0]         r_t_data;      // second (tail) word
  logic [c_WA_W-1:0]   r_t_waddr;
`endif

  // --------------------------------------------------------------------------
  // Handshake, buffer occupancy and request decision
  // --------------------------------------------------------------------------
  logic       w_run;
  logic       w_valid;
  logic       w_xfer;
  logic       w_pop;
  logic       w_rsp_ok;
  logic       w_push;
  logic [1:0] w_keep;
  logic [2:0] w_level;
  logic       w_req;

  always_comb begin
    w_run    = (r_state == ST_RUN);
    w_valid  = w_run && (r_count != 2'd0);
    w_xfer   = w_valid && inst_ready;
    // Consuming the last byte of the head word retires that word.
    w_pop    = w_xfer && (r_ofs == 2'd3);
    // Responses to requests issued before the latest redirect are dropped.
    w_rsp_ok = r_pend && (r_pend_epoch == r_epoch);
    w_push   = w_rsp_ok && !redirect;
    w_keep   = r_count - {1'b0, w_pop};
    // Words that will be held after this edge, counting the arriving one.
    w_level  = {1'b0, w_keep} + {2'b00, w_rsp_ok};
    // Only one request outstanding at a time: never issue back to back, and
    // an arriving response is already accounted for in w_level.
    w_req    = w_run && !r_mem_req && (w_level < c_BUF_N);
  end

  // --------------------------------------------------------------------------
  // Control FSM and memory request generation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_waddr  <= '0;
      r_fa         <= '0;
      r_epoch      <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_epoch <= 1'b0;
    end else begin
      // The epoch seen while mem_req is high is the epoch of that request; a
      // redirect in that same cycle flips r_epoch so the response mismatches.
      r_pend       <= r_mem_req;
      r_pend_epoch <= r_epoch;

      case (r_state)
        ST_IDLE: begin
          r_mem_req <= 1'b0;
          if (redirect) begin
            r_state     <= ST_RUN;
            r_epoch     <= ~r_epoch;
            r_mem_req   <= 1'b1;
            r_mem_waddr <= redirect_pc[ADDR_W-1:2];
            r_fa        <= redirect_pc[ADDR_W-1:2] + c_WA_ONE;
          end
        end

        ST_RUN: begin
          if (redirect) begin
            // Restart immediately, regardless of any request in flight.
            r_epoch     <= ~r_epoch;
            r_mem_req   <= 1'b1;
            r_mem_waddr <= redirect_pc[ADDR_W-1:2];
            r_fa        <= redirect_pc[ADDR_W-1:2] + c_WA_ONE;
          end else if (w_req) begin
            r_mem_req   <= 1'b1;
            r_mem_waddr <= r_fa;
            r_fa        <= r_fa + c_WA_ONE;
          end else begin
            r_mem_req   <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Word buffer and byte offset
  // --------------------------------------------------------------------------
  // r_mem_waddr still holds the address of the request while its response is
  // on mem_rdata: a new request can only be launched at the end of that cycle,
  // and a redirect in between makes the response stale anyway.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count   <= 2'd0;
      r_ofs     <= 2'd0;
      r_h_data  <= '0;
      r_h_waddr <= '0;
`ifdef FEEDER_PREFETCH_EN
      r_t_data  <= '0;
      r_t_waddr <= '0;
`endif
    end else if (redirect) begin
      // Bytes below the target offset in the first word are skipped simply by
      // starting the offset there; later words start at 0 via wrap-around.
      r_count <= 2'd0;
      r_ofs   <= redirect_pc[1:0];
    end else begin
      if (w_xfer) begin
        r_ofs <= r_ofs + 2'd1;
      end
      r_count <= w_keep + {1'b0, w_push};

`ifdef FEEDER_PREFETCH_EN
      if (w_pop && (r_count == 2'd2)) begin
        r_h_data  <= r_t_data;
        r_h_waddr <= r_t_waddr;
      end
      if (w_push && (w_keep == 2'd1)) begin
        r_t_data  <= mem_rdata;
        r_t_waddr <= r_mem_waddr;
      end
`endif
      if (w_push && (w_keep == 2'd0)) begin
        r_h_data  <= mem_rdata;
        r_h_waddr <= r_mem_waddr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    inst = r_h_data[7:0];
    case (r_ofs)
      2'd0:    inst = r_h_data[7:0];
      2'd1:    inst = r_h_data[15:8];
      2'd2:    inst = r_h_data[23:16];
      2'd3:    inst = r_h_data[31:24];
      default: inst = r_h_data[7:0];
    endcase
  end

  assign pc         = {r_h_waddr, r_ofs};
  assign inst_valid = w_valid;
  assign mem_req    = r_mem_req;
  assign mem_addr   = {r_mem_waddr, 2'b00};

endmodule
`default_nettype wire
